// File: rtl/decode_prefix_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// decode_prefix_sequencer_pkg
// Shared definitions for the x86 prefix/escape sequencer.
// Contents: legacy prefix byte values, escape byte values, REP and segment
// override encodings, prefix group codes and the sequencer state encoding.
// -----------------------------------------------------------------------------
package decode_prefix_sequencer_pkg;

    // Legacy prefix bytes
    localparam logic [7:0] PFX_LOCK     = 8'hF0;
    localparam logic [7:0] PFX_REPNE    = 8'hF2;
    localparam logic [7:0] PFX_REP      = 8'hF3;
    localparam logic [7:0] PFX_ES       = 8'h26;
    localparam logic [7:0] PFX_CS       = 8'h2E;
    localparam logic [7:0] PFX_SS       = 8'h36;
    localparam logic [7:0] PFX_DS       = 8'h3E;
    localparam logic [7:0] PFX_FS       = 8'h64;
    localparam logic [7:0] PFX_GS       = 8'h65;
    localparam logic [7:0] PFX_OPSIZE   = 8'h66;
    localparam logic [7:0] PFX_ADDRSIZE = 8'h67;

    // Escape bytes: 0F opens the two-byte map; 38/3A would need a
    // three-byte map, which this sequencer does not support.
    localparam logic [7:0] ESC_0F = 8'h0F;
    localparam logic [7:0] ESC_38 = 8'h38;
    localparam logic [7:0] ESC_3A = 8'h3A;

    // REP group encoding
    localparam logic [1:0] REP_NONE = 2'b00;
    localparam logic [1:0] REP_F3   = 2'b01;
    localparam logic [1:0] REP_F2   = 2'b10;

    // Segment override encoding
    localparam logic [2:0] SEG_NONE = 3'd0;
    localparam logic [2:0] SEG_ES   = 3'd1;
    localparam logic [2:0] SEG_CS   = 3'd2;
    localparam logic [2:0] SEG_SS   = 3'd3;
    localparam logic [2:0] SEG_DS   = 3'd4;
    localparam logic [2:0] SEG_FS   = 3'd5;
    localparam logic [2:0] SEG_GS   = 3'd6;

    // Prefix group codes produced by the classifier
    localparam logic [2:0] GRP_NONE     = 3'd0;
    localparam logic [2:0] GRP_LOCK     = 3'd1;
    localparam logic [2:0] GRP_REP      = 3'd2;
    localparam logic [2:0] GRP_SEG      = 3'd3;
    localparam logic [2:0] GRP_OPSIZE   = 3'd4;
    localparam logic [2:0] GRP_ADDRSIZE = 3'd5;

    // Maximum number of prefixes stripped before the window is rejected
    localparam logic [2:0] MAX_PREFIX = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_ESC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // True for an escape follow-up byte that selects an unsupported map
    function automatic logic is_esc_fault(input logic [7:0] b);
        return (b == ESC_38) || (b == ESC_3A);
    endfunction

endpackage

// File: rtl/decode_prefix_classify.sv
// -----------------------------------------------------------------------------
// decode_prefix_classify
// Purely combinational classifier for one instruction byte.
// Ports:
//   data_byte  in  8  byte to classify
//   is_prefix  out 1  byte is a legacy prefix
//   group      out 3  prefix group (GRP_*), GRP_NONE when not a prefix
//   value      out 3  encoded value inside the group (REP_* or SEG_*)
//   is_escape  out 1  byte is the 0x0F escape
// -----------------------------------------------------------------------------
module decode_prefix_classify
    import decode_prefix_sequencer_pkg::*;
(
    input  logic [7:0] data_byte,
    output logic       is_prefix,
    output logic [2:0] group,
    output logic [2:0] value,
    output logic       is_escape
);

    // Decode the byte into prefix group and in-group encoding
    always_comb begin
        is_prefix = 1'b1;
        group     = GRP_NONE;
        value     = 3'd0;
        is_escape = 1'b0;
        case (data_byte)
            PFX_LOCK:     group = GRP_LOCK;
            PFX_REP:      begin group = GRP_REP; value = {1'b0, REP_F3}; end
            PFX_REPNE:    begin group = GRP_REP; value = {1'b0, REP_F2}; end
            PFX_ES:       begin group = GRP_SEG; value = SEG_ES; end
            PFX_CS:       begin group = GRP_SEG; value = SEG_CS; end
            PFX_SS:       begin group = GRP_SEG; value = SEG_SS; end
            PFX_DS:       begin group = GRP_SEG; value = SEG_DS; end
            PFX_FS:       begin group = GRP_SEG; value = SEG_FS; end
            PFX_GS:       begin group = GRP_SEG; value = SEG_GS; end
            PFX_OPSIZE:   group = GRP_OPSIZE;
            PFX_ADDRSIZE: group = GRP_ADDRSIZE;
            ESC_0F:       begin is_prefix = 1'b0; is_escape = 1'b1; end
            default:      is_prefix = 1'b0;
        endcase
    end

endmodule

// File: rtl/decode_prefix_sequencer.sv
// -----------------------------------------------------------------------------
// decode_prefix_sequencer
// Strips up to four legacy prefixes and an optional 0x0F escape from a raw
// 15-byte x86 instruction window, one byte per cycle, and reports the
// collected prefix state together with the remaining window.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_valid/in_ready/in_instr   window input handshake (byte 0 in [7:0])
//   out_valid/out_ready          result handshake
//   out_unescaped             window after stripping, opcode byte in [7:0]
//   out_is_2byte              0x0F escape consumed
//   out_consumed              number of stripped bytes (prefixes + escape)
//   out_lock/out_rep/out_seg/out_opsize/out_addrsize   collected prefixes
//   out_fault                 too many prefixes or unsupported escape map
// -----------------------------------------------------------------------------
module decode_prefix_sequencer
    import decode_prefix_sequencer_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [119:0] in_instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [87:0]  out_unescaped,
    output logic         out_is_2byte,
    output logic [2:0]   out_consumed,
    output logic         out_lock,
    output logic [1:0]   out_rep,
    output logic [2:0]   out_seg,
    output logic         out_opsize,
    output logic         out_addrsize,
    output logic         out_fault
);

    state_e       state_r,    state_next_s;
    logic [119:0] sr_r,       sr_next_s;
    logic [2:0]   consumed_r, consumed_next_s;
    logic         lock_r,     lock_next_s;
    logic [1:0]   rep_r,      rep_next_s;
    logic [2:0]   seg_r,      seg_next_s;
    logic         opsize_r,   opsize_next_s;
    logic         addrsize_r, addrsize_next_s;
    logic         is_2byte_r, is_2byte_next_s;
    logic         fault_r,    fault_next_s;
    logic         out_valid_r;
    logic         in_ready_r;

    logic         cls_is_prefix_s;
    logic [2:0]   cls_group_s;
    logic [2:0]   cls_value_s;
    logic         cls_is_escape_s;

    decode_prefix_classify u_classify (
        .data_byte (sr_r[7:0]),
        .is_prefix (cls_is_prefix_s),
        .group     (cls_group_s),
        .value     (cls_value_s),
        .is_escape (cls_is_escape_s)
    );

    // Next-state and datapath update; every register holds unless changed
    always_comb begin
        state_next_s    = state_r;
        sr_next_s       = sr_r;
        consumed_next_s = consumed_r;
        lock_next_s     = lock_r;
        rep_next_s      = rep_r;
        seg_next_s      = seg_r;
        opsize_next_s   = opsize_r;
        addrsize_next_s = addrsize_r;
        is_2byte_next_s = is_2byte_r;
        fault_next_s    = fault_r;

        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    sr_next_s       = in_instr;
                    consumed_next_s = 3'd0;
                    lock_next_s     = 1'b0;
                    rep_next_s      = REP_NONE;
                    seg_next_s      = SEG_NONE;
                    opsize_next_s   = 1'b0;
                    addrsize_next_s = 1'b0;
                    is_2byte_next_s = 1'b0;
                    fault_next_s    = 1'b0;
                    state_next_s    = ST_SCAN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_SCAN: begin
                // While scanning, the counter holds only prefixes stripped so far
                if (cls_is_prefix_s) begin
                    if (consumed_r < MAX_PREFIX) begin
                        // Later prefix in the same group overrides the earlier one
                        case (cls_group_s)
                            GRP_LOCK:     lock_next_s     = 1'b1;
                            GRP_REP:      rep_next_s      = cls_value_s[1:0];
                            GRP_SEG:      seg_next_s      = cls_value_s;
                            GRP_OPSIZE:   opsize_next_s   = 1'b1;
                            GRP_ADDRSIZE: addrsize_next_s = 1'b1;
                            default:      lock_next_s     = lock_r;
                        endcase
                        sr_next_s       = {8'h00, sr_r[119:8]};
                        consumed_next_s = consumed_r + 3'd1;
                        state_next_s    = ST_SCAN;
                    end else begin
                        // Fifth prefix: leave it in byte 0 for diagnosis
                        fault_next_s = 1'b1;
                        state_next_s = ST_DONE;
                    end
                end else if (cls_is_escape_s) begin
                    is_2byte_next_s = 1'b1;
                    sr_next_s       = {8'h00, sr_r[119:8]};
                    consumed_next_s = consumed_r + 3'd1;
                    state_next_s    = ST_ESC;
                end else begin
                    state_next_s = ST_DONE;
                end
            end

            ST_ESC: begin
                if (is_esc_fault(sr_r[7:0])) begin
                    fault_next_s = 1'b1;
                end else begin
                    fault_next_s = fault_r;
                end
                state_next_s = ST_DONE;
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end

            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            sr_r        <= 120'd0;
            consumed_r  <= 3'd0;
            lock_r      <= 1'b0;
            rep_r       <= REP_NONE;
            seg_r       <= SEG_NONE;
            opsize_r    <= 1'b0;
            addrsize_r  <= 1'b0;
            is_2byte_r  <= 1'b0;
            fault_r     <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            sr_r        <= sr_next_s;
            consumed_r  <= consumed_next_s;
            lock_r      <= lock_next_s;
            rep_r       <= rep_next_s;
            seg_r       <= seg_next_s;
            opsize_r    <= opsize_next_s;
            addrsize_r  <= addrsize_next_s;
            is_2byte_r  <= is_2byte_next_s;
            fault_r     <= fault_next_s;
            // Handshake flags are decoded from the next state so they are
            // plain flops that always agree with state_r
            out_valid_r <= (state_next_s == ST_DONE);
            in_ready_r  <= (state_next_s == ST_IDLE);
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign out_unescaped = sr_r[87:0];
    assign out_is_2byte  = is_2byte_r;
    assign out_consumed  = consumed_r;
    assign out_lock      = lock_r;
    assign out_rep       = rep_r;
    assign out_seg       = seg_r;
    assign out_opsize    = opsize_r;
    assign out_addrsize  = addrsize_r;
    assign out_fault     = fault_r;

endmodule

// File: tb/tb_decode_prefix_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decode_prefix_sequencer
// Directed self-checking bench for decode_prefix_sequencer. Inputs change and
// outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_decode_prefix_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [119:0] in_instr;
    logic         out_valid;
    logic         out_ready;
    logic [87:0]  out_unescaped;
    logic         out_is_2byte;
    logic [2:0]   out_consumed;
    logic         out_lock;
    logic [1:0]   out_rep;
    logic [2:0]   out_seg;
    logic         out_opsize;
    logic         out_addrsize;
    logic         out_fault;

    int n_cmp  = 0;
    int n_fail = 0;

    decode_prefix_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_unescaped (out_unescaped),
        .out_is_2byte  (out_is_2byte),
        .out_consumed  (out_consumed),
        .out_lock      (out_lock),
        .out_rep       (out_rep),
        .out_seg       (out_seg),
        .out_opsize    (out_opsize),
        .out_addrsize  (out_addrsize),
        .out_fault     (out_fault)
    );

    always #5 clk = ~clk;

    // Offer one window while idle; lat returns k where out_valid first
    // appears in cycle N+k (N = accept cycle). Bounded at 40 cycles.
    task automatic send(input logic [119:0] w, output int lat);
        in_instr = w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_instr = '0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Complete the output handshake
    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if ({out_fault, out_is_2byte, out_consumed, out_lock, out_rep, out_seg, out_opsize, out_addrsize} !== 13'd0)
            begin n_fail++; $display("FAIL reset_fields got %b want 0", {out_fault, out_is_2byte, out_consumed, out_lock, out_rep, out_seg, out_opsize, out_addrsize}); end
        n_cmp++; if (out_unescaped !== 88'd0) begin n_fail++; $display("FAIL reset_window got %h want 0", out_unescaped); end
    endtask

    task automatic test_nop();
        int lat;
        send(120'h90, lat);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL nop_latency got %0d want 2", lat); end
        n_cmp++; if (out_consumed !== 3'd0 || out_is_2byte !== 1'b0 || out_fault !== 1'b0)
            begin n_fail++; $display("FAIL nop_flags got cons=%0d 2b=%b flt=%b want 0/0/0", out_consumed, out_is_2byte, out_fault); end
        n_cmp++; if (out_unescaped !== 88'h90) begin n_fail++; $display("FAIL nop_window got %h want 90", out_unescaped); end
        take_result();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL nop_release got v=%b r=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_rep_escape();
        int lat;
        out_ready = 1'b1;   // must be ignored until DONE
        send(120'h11_22_B8_0F_F3_66, lat);
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL repesc_latency got %0d want 5", lat); end
        n_cmp++; if (out_opsize !== 1'b1 || out_rep !== 2'b01 || out_is_2byte !== 1'b1 || out_consumed !== 3'd3 || out_fault !== 1'b0)
            begin n_fail++; $display("FAIL repesc_fields got op=%b rep=%b 2b=%b cons=%0d flt=%b want 1/01/1/3/0",
                out_opsize, out_rep, out_is_2byte, out_consumed, out_fault); end
        n_cmp++; if (out_unescaped !== 88'h11_22_B8) begin n_fail++; $display("FAIL repesc_window got %h want 1122b8", out_unescaped); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL repesc_release got v=%b r=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_seg_hold();
        int lat;
        send(120'h89_64_2E, lat);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL seg_latency got %0d want 4", lat); end
        n_cmp++; if (out_seg !== 3'd5 || out_consumed !== 3'd2 || out_unescaped !== 88'h89)
            begin n_fail++; $display("FAIL seg_fields got seg=%0d cons=%0d win=%h want 5/2/89", out_seg, out_consumed, out_unescaped); end
        // New window offered while busy must be ignored; outputs hold
        in_valid = 1'b1;
        in_instr = 120'h90_F0_F0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_seg !== 3'd5 || out_consumed !== 3'd2 ||
                         out_unescaped !== 88'h89 || out_lock !== 1'b0 || out_fault !== 1'b0)
                begin n_fail++; $display("FAIL hold_cycle%0d got v=%b r=%b seg=%0d cons=%0d win=%h lock=%b want 1/0/5/2/89/0",
                    i, out_valid, in_ready, out_seg, out_consumed, out_unescaped, out_lock); end
        end
        in_valid = 1'b0;
        in_instr = '0;
        take_result();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL seg_release got v=%b r=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_prefix_fault();
        int lat;
        send(120'h01_26_F2_67_66_F0, lat);
        n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL pfxflt_latency got %0d want 6", lat); end
        n_cmp++; if (out_fault !== 1'b1 || out_consumed !== 3'd4 || out_unescaped[7:0] !== 8'h26)
            begin n_fail++; $display("FAIL pfxflt_fields got flt=%b cons=%0d b0=%h want 1/4/26", out_fault, out_consumed, out_unescaped[7:0]); end
        n_cmp++; if (out_lock !== 1'b1 || out_opsize !== 1'b1 || out_addrsize !== 1'b1 || out_rep !== 2'b10 || out_seg !== 3'd0)
            begin n_fail++; $display("FAIL pfxflt_prefixes got lk=%b op=%b ad=%b rep=%b seg=%0d want 1/1/1/10/0",
                out_lock, out_opsize, out_addrsize, out_rep, out_seg); end
        take_result();
    endtask

    task automatic test_escape_fault();
        int lat;
        send(120'h00_38_0F, lat);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL escflt_latency got %0d want 3", lat); end
        n_cmp++; if (out_fault !== 1'b1 || out_is_2byte !== 1'b1 || out_consumed !== 3'd1 || out_unescaped[7:0] !== 8'h38)
            begin n_fail++; $display("FAIL escflt_fields got flt=%b 2b=%b cons=%0d b0=%h want 1/1/1/38",
                out_fault, out_is_2byte, out_consumed, out_unescaped[7:0]); end
        take_result();
    endtask

    // Immediately after a faulting result, a fresh window must clear all state
    task automatic test_back_to_back();
        int lat;
        send(120'h5A_C3, lat);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_latency got %0d want 2", lat); end
        n_cmp++; if (out_fault !== 1'b0 || out_is_2byte !== 1'b0 || out_consumed !== 3'd0 || out_lock !== 1'b0 ||
                     out_opsize !== 1'b0 || out_addrsize !== 1'b0 || out_rep !== 2'b00 || out_seg !== 3'd0)
            begin n_fail++; $display("FAIL b2b_cleared got flt=%b 2b=%b cons=%0d lk=%b op=%b ad=%b rep=%b seg=%0d want all 0",
                out_fault, out_is_2byte, out_consumed, out_lock, out_opsize, out_addrsize, out_rep, out_seg); end
        n_cmp++; if (out_unescaped !== 88'h5A_C3) begin n_fail++; $display("FAIL b2b_window got %h want 5ac3", out_unescaped); end
        take_result();
    endtask

    task automatic test_reset_abort();
        int seen;
        in_instr = 120'h90_66_66;
        in_valid = 1'b1;
        @(posedge clk); #1;          // cycle N+1: first SCAN
        in_valid = 1'b0;
        in_instr = '0;
        @(posedge clk); #1;          // cycle N+2: second SCAN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL abort_after_rst got r=%b v=%b want 1/0", in_ready, out_valid); end
        n_cmp++; if (out_consumed !== 3'd0 || out_opsize !== 1'b0 || out_unescaped !== 88'd0)
            begin n_fail++; $display("FAIL abort_cleared got cons=%0d op=%b win=%h want 0/0/0", out_consumed, out_opsize, out_unescaped); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_output got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_rep_escape();
        test_seg_hold();
        test_prefix_fault();
        test_back_to_back();
        test_escape_fault();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
